// File: rtl/sync_mem_responder.sv
// Slave end of the synchronous memory bus: zero-fills its array after reset,
// then serves one read/write per cycle with a fixed-latency in-order response.
module sync_mem_responder #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_SIZE     = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  slv_rsp,
    output logic                  busy,
    output logic                  err
);
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic {INIT, RUN} state_t;
    typedef struct packed {
        logic                  rd;
        logic [DATA_WIDTH-1:0] dat;
    } rsp_t;

    state_t                  state;
    logic [IDX_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

    logic [READ_LATENCY:1]   vld_pipe, vld_nxt;
    rsp_t                    dat_pipe [READ_LATENCY:1];
    rsp_t                    dat_nxt  [READ_LATENCY:1];

    logic [IDX_W-1:0]        idx;
    logic                    oob, accept;

    assign idx     = addr[IDX_W-1:0];
    assign oob     = {1'b0, addr} >= (ADDR_WIDTH+1)'(MEM_SIZE);
    assign accept  = (state == RUN) && (wr ^ rd);
    assign slv_rsp = vld_pipe[READ_LATENCY];

    // Stage 1 captures the array at the request edge, so a write one edge
    // earlier is already visible to the read.
    always_comb begin
        vld_nxt[1] = accept;
        dat_nxt[1] = '{rd: rd, dat: (rd && !oob) ? mem[idx] : '0};
        for (int k = 2; k <= READ_LATENCY; k++) begin
            vld_nxt[k] = vld_pipe[k-1];
            dat_nxt[k] = dat_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            cnt      <= '0;
            busy     <= 1'b1;
            err      <= 1'b0;
            rdata    <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= vld_nxt;
            for (int k = 1; k <= READ_LATENCY; k++)
                dat_pipe[k] <= dat_nxt[k];
            // rdata loads on the same edge that raises slv_rsp for a read
            if (vld_nxt[READ_LATENCY] && dat_nxt[READ_LATENCY].rd)
                rdata <= dat_nxt[READ_LATENCY].dat;

            case (state)
                INIT: begin
                    mem[cnt] <= '0;
                    cnt      <= cnt + 1'b1;
                    err      <= wr | rd;
                    if (cnt == IDX_W'(MEM_SIZE - 1)) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    err <= (wr && rd) || ((wr ^ rd) && oob);
                    if (wr && !rd && !oob)
                        mem[idx] <= wdata;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sync_mem_responder.sv
// Drives three responder configurations in lockstep and compares every output,
// every cycle, against an event-scheduled behavioural model.
module tb_sync_mem_responder;
    localparam int NI = 3;
    localparam int LAT [NI] = '{1, 3, 2};
    localparam int MSZ [NI] = '{16, 16, 12};

    logic        clk, reset, wr, rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata_o [NI];
    logic        slv_rsp_o [NI], busy_o [NI], err_o [NI];

    int checks = 0, failures = 0;

    sync_mem_responder #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(16), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
        .rdata(rdata_o[0]), .slv_rsp(slv_rsp_o[0]), .busy(busy_o[0]), .err(err_o[0]));
    sync_mem_responder #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(16), .READ_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
        .rdata(rdata_o[1]), .slv_rsp(slv_rsp_o[1]), .busy(busy_o[1]), .err(err_o[1]));
    sync_mem_responder #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(12), .READ_LATENCY(2)) dut_c (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
        .rdata(rdata_o[2]), .slv_rsp(slv_rsp_o[2]), .busy(busy_o[2]), .err(err_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: memory contents, busy countdown, and pending responses keyed by due edge.
    int          cyc = 0;
    int          busy_cnt [NI];
    logic [31:0] mmem [NI][16];
    bit          due_v [NI][8];
    bit          due_rd [NI][8];
    logic [31:0] due_dat [NI][8];
    bit          e_rsp [NI], e_err [NI], e_busy [NI];
    logic [31:0] e_rdata [NI];

    task automatic model_edge();
        cyc++;
        for (int i = 0; i < NI; i++) begin
            bit err_n;
            int slot;
            if (reset) begin
                busy_cnt[i] = MSZ[i];
                for (int j = 0; j < 16; j++) mmem[i][j] = 32'h0;
                for (int j = 0; j < 8; j++) due_v[i][j] = 1'b0;
                e_rsp[i] = 1'b0; e_err[i] = 1'b0; e_rdata[i] = 32'h0; e_busy[i] = 1'b1;
                continue;
            end
            err_n = 1'b0;
            if (busy_cnt[i] > 0) begin
                err_n = wr | rd;
                busy_cnt[i]--;
            end else if (wr && rd) begin
                err_n = 1'b1;
            end else if (wr || rd) begin
                bit oob;
                oob = int'(addr) >= MSZ[i];
                err_n = oob;
                if (wr && !oob) mmem[i][addr] = wdata;
                slot = (cyc + LAT[i] - 1) % 8;
                due_v[i][slot]   = 1'b1;
                due_rd[i][slot]  = rd;
                due_dat[i][slot] = (rd && !oob) ? mmem[i][addr] : 32'h0;
            end
            slot = cyc % 8;
            e_rsp[i] = due_v[i][slot];
            if (due_v[i][slot] && due_rd[i][slot]) e_rdata[i] = due_dat[i][slot];
            due_v[i][slot] = 1'b0;
            e_err[i]  = err_n;
            e_busy[i] = busy_cnt[i] > 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit w, input bit q, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = r; wr = w; rd = q; addr = a; wdata = d;
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(e_busy[i]));
            chk($sformatf("slv_rsp[%0d]", i), 32'(slv_rsp_o[i]), 32'(e_rsp[i]));
            chk($sformatf("err[%0d]", i), 32'(err_o[i]), 32'(e_err[i]));
            chk($sformatf("rdata[%0d]", i), rdata_o[i], e_rdata[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < NI; i++) busy_cnt[i] = 0;

        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 4'h2, 32'h1234);      // ignored while clearing
        idle(14);

        step(1'b0, 1'b0, 1'b1, 4'h5, 32'h0);
        idle(4);

        step(1'b0, 1'b1, 1'b0, 4'h3, 32'hDEADBEEF);
        step(1'b0, 1'b0, 1'b1, 4'h3, 32'h0);
        chk("deadbeef_lat1", rdata_o[0], 32'hDEADBEEF);
        idle(4);

        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b0, 4'(k), 32'(k) * 32'h11111111);
        for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 1'b1, 4'(k), 32'h0);
        idle(5);

        step(1'b0, 1'b1, 1'b1, 4'h7, 32'hFFFF0000);   // both asserted
        step(1'b0, 1'b0, 1'b1, 4'h7, 32'h0);
        step(1'b0, 1'b0, 1'b1, 4'h2, 32'h0);
        idle(4);

        step(1'b0, 1'b0, 1'b1, 4'd13, 32'h0);         // out of range for the 12-word copy
        step(1'b0, 1'b1, 1'b0, 4'd14, 32'hAA);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b1, 4'(k), 32'h0);
        idle(4);

        step(1'b0, 1'b1, 1'b0, 4'h4, 32'h55);
        step(1'b0, 1'b0, 1'b1, 4'h4, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);          // reset while the read is in flight
        idle(20);
        step(1'b0, 1'b0, 1'b1, 4'h4, 32'h0);
        idle(4);

        for (int n = 0; n < 400; n++) begin
            int op;
            bit r;
            r  = ($urandom_range(63) == 0);
            op = $urandom_range(7);
            step(r, (op <= 2) || (op == 7), (op >= 3 && op <= 5) || (op == 7),
                 4'($urandom_range(15)), $urandom);
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_mem_responder.md
Name: sync_mem_responder

Overview:
- Memory-side responder for the synchronous read/write memory bus: the slave end of the memory interface.
- Samples wr/rd/addr/wdata driven by the initiator on each rising clk edge, services a MEM_SIZE x DATA_WIDTH storage array, and returns rdata.
- Acknowledges every accepted request with slv_rsp after a fixed pipeline latency.
- After reset, clears the array itself, reporting busy while it does so.

Parameters:
- ADDR_WIDTH, 4, address bus width in bits.
- DATA_WIDTH, 32, width of wdata/rdata in bits.
- MEM_SIZE, 16, number of words; legal range 2..2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from request sample to slv_rsp; legal range 1..4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  write request, sampled each edge.
- rd  input  1  read request, sampled each edge.
- addr  input  ADDR_WIDTH  word address.
- wdata  input  DATA_WIDTH  write data.
- rdata  output  DATA_WIDTH  read data; valid when slv_rsp=1 for a read.
- slv_rsp  output  1  one-cycle completion pulse per accepted request.
- busy  output  1  high while the post-reset clear is running; requests are ignored.
- err  output  1  one-cycle protocol error pulse.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset, sampled at an edge:
  - state<=INIT, clear counter<=0, response pipeline flushed.
  - rdata<=0, slv_rsp<=0, err<=0, busy<=1.
  - In-flight requests never produce slv_rsp.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle writes 0 to mem[cnt], then cnt increments.
  - After the write of index MEM_SIZE-1: state<=RUN, busy<=0.
  - busy is therefore high for exactly MEM_SIZE cycles after the first edge with reset=0.
- Requests while busy=1: no memory effect, no slv_rsp. err pulses if wr or rd was high.
- RUN, request sampled at edge N. Exactly one of wr/rd must be 1.
  - Write (wr=1, rd=0): mem[addr]<=wdata at edge N.
  - Read (rd=1, wr=0): array read at edge N. The result is the latest value, so a write at edge N-1 to the same address is visible.
  - Both kinds are tagged and enter a READ_LATENCY-deep in-order pipeline.
  - slv_rsp=1 during the cycle after edge N+READ_LATENCY-1, i.e. registered output; READ_LATENCY=1 means high in cycle N+1.
  - A read response loads rdata at the same edge that raises slv_rsp.
  - A write response leaves rdata unchanged.
- rdata holds its last read value between read responses.
- Throughput: one request per cycle, back-to-back, no stalls. Responses are strictly in request order with no response collisions.
- wr=1 and rd=1 together: no operation, no slv_rsp, err pulses in cycle N+1.
- addr >= MEM_SIZE (only possible when MEM_SIZE < 2^ADDR_WIDTH):
  - Write is dropped; a read returns 0.
  - slv_rsp still asserted at normal latency.
  - err pulses in cycle N+1.
- err is always registered at latency 1, independent of READ_LATENCY. err never pulses for legal requests.
- Idle cycle (wr=0, rd=0): nothing happens; slv_rsp stays low for that slot.
- Reset mid-pipeline (e.g. READ_LATENCY=3, reset asserted one cycle after a read):
  - Pipeline cleared; slv_rsp stays 0.
  - Memory is re-cleared by INIT.

Test Plan:
- Reset, defaults -> busy=1 for 16 cycles then 0; rdata=0, slv_rsp=0, err=0. A read of addr 5 after busy falls returns 0x00000000.
- Write 0xDEADBEEF to addr 3 at edge N, read addr 3 at edge N+1 -> slv_rsp at N+1 (write, rdata unchanged) and at N+2 with rdata=0xDEADBEEF.
- READ_LATENCY=3: back-to-back reads of addr 0..15 after writing data=addr*0x11111111 -> 16 consecutive slv_rsp pulses starting 3 cycles after the first request; data in order, 0x00000000..0xFFFFFFFF.
- wr=1 and rd=1 at addr 7; also a write of 0x1234 to addr 2 while busy=1 -> err=1 for one cycle each, no slv_rsp. mem[7] and mem[2] both read back 0 later.
- MEM_SIZE=12: read addr 13 and write 0xAA to addr 14 -> slv_rsp for both, rdata=0, err pulse each; mem[0..11] unchanged.
- READ_LATENCY=3: read addr 4 (holding 0x55), assert reset for 1 cycle the next cycle -> no slv_rsp ever for that read; busy re-asserts for 16 cycles; addr 4 then reads 0.
